mpeg_stream_demux: RTL and testbench

- Parametrised MPEG-1 system-stream demultiplexer. Parses pack headers and PES packet headers from a byte stream.
- Routes payload bytes of up to NUM_CH selected elementary streams to a tagged byte output.
- Reports SCR, PTS and DTS, plus a per-channel start time in the 45 kHz dclk domain.
- Sits between the sector/CD-data path and the MPEG audio/video decoders. Replaces single-stream header snooping with length-accurate parsing and stream filtering.

---
 rtl/mpeg_demux_pkg.sv | 30 +++
 rtl/mpeg_ts_capture.sv | 25 ++
 rtl/mpeg_stream_demux.sv | 245 ++++++++++++++++++++++++
 tb/tb_mpeg_stream_demux.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg_demux_pkg.sv
// Shared types, start-code constants and timestamp helpers for the MPEG-1 system-stream demux.
package mpeg_demux_pkg;

   typedef enum logic [3:0] {
      HUNT, Z1, Z2, SC, PACK, LEN_H, LEN_L, SKIP, HDR, STD2, TS, PAYLOAD
   } state_t;

   localparam logic [7:0] SC_PACK   = 8'hBA;
   localparam logic [7:0] SC_END    = 8'hB9;
   localparam logic [7:0] SC_SYSHDR = 8'hBB;
   localparam logic [7:0] SC_PAD    = 8'hBE;
   localparam logic [7:0] SC_PRIV2  = 8'hBF;

   localparam logic [7:0] ES_ID_MIN = 8'hC0;
   localparam logic [7:0] ES_ID_MAX = 8'hEF;

   localparam logic [7:0] HDR_STUFF = 8'hFF;
   localparam logic [7:0] HDR_NO_TS = 8'h0F;
   localparam int         MAX_STUFF = 16;

   // Five stream bytes b0..b4 (b0 in the top byte) into a 33-bit clock value.
   function automatic logic [32:0] ts_assemble(input logic [39:0] b);
      return {b[35:33], b[31:24], b[23:17], b[15:8], b[7:1]};
   endfunction

   function automatic logic ts_markers_ok(input logic [39:0] b);
      return b[32] & b[16] & b[0];
   endfunction

endpackage

// File: rtl/mpeg_ts_capture.sv
// Keeps the last four stream bytes so the current byte completes a 5-byte SCR/PTS/DTS field.
module mpeg_ts_capture
   import mpeg_demux_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        shift,
   input  logic [7:0]  data,
   output logic [32:0] value,
   output logic        markers_ok
);

   logic [31:0] history;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         history <= '0;
      else if (shift)
         history <= {history[23:0], data};
   end

   assign value      = ts_assemble({history, data});
   assign markers_ok = ts_markers_ok({history, data});

endmodule

// File: rtl/mpeg_stream_demux.sv
// MPEG-1 system-stream demux: pack/PES header parsing, stream filtering onto tagged payload
// channels, SCR/PTS/DTS reporting and per-channel start times in the dclk domain.
module mpeg_stream_demux
   import mpeg_demux_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            mpeg_data,
   input  logic                  data_valid,
   input  logic [8*NUM_CH-1:0]   stream_id_sel,
   input  logic [31:0]           dclk,
   output logic [7:0]            payload_data,
   output logic                  payload_valid,
   output logic [CHW-1:0]        payload_ch,
   output logic                  payload_last,
   output logic [32:0]           scr,
   output logic                  scr_valid,
   output logic [32:0]           pts,
   output logic [32:0]           dts,
   output logic                  ts_valid,
   output logic [CHW-1:0]        ts_ch,
   output logic [33*NUM_CH-1:0]  start_time,
   output logic [NUM_CH-1:0]     start_valid,
   output logic                  end_seen,
   output logic [15:0]           err_cnt
);

   state_t              state;
   logic [2:0]          pack_idx;
   logic [3:0]          ts_idx;
   logic                has_dts;
   logic                matched;
   logic [7:0]          len_hi;
   logic [15:0]         remaining;
   logic [4:0]          stuff_cnt;
   logic [CHW-1:0]      ch;
   logic [32:0]         pts_hold;
   logic [8*NUM_CH-1:0] sel_q;

   logic [32:0] ts_value;
   logic        markers_ok;

   mpeg_ts_capture u_ts_capture (
      .clk        (clk),
      .reset_n    (reset_n),
      .shift      (data_valid),
      .data       (mpeg_data),
      .value      (ts_value),
      .markers_ok (markers_ok)
   );

   logic is_es, sc_known, is_stuff, is_std, is_pts, is_ptsdts, hdr_known;
   logic rem_last, ts_final;
   logic [32:0] new_pts, start_calc;

   assign is_es     = (mpeg_data >= ES_ID_MIN) && (mpeg_data <= ES_ID_MAX);
   assign sc_known  = (mpeg_data == SC_PACK) || (mpeg_data == SC_END) || (mpeg_data == SC_SYSHDR) ||
                      (mpeg_data == SC_PAD) || (mpeg_data == SC_PRIV2) || is_es;
   assign is_stuff  = (mpeg_data == HDR_STUFF);
   assign is_std    = (mpeg_data[7:6] == 2'b01);
   assign is_pts    = (mpeg_data[7:4] == 4'b0010) && mpeg_data[0];
   assign is_ptsdts = (mpeg_data[7:4] == 4'b0011) && mpeg_data[0];
   assign hdr_known = is_stuff || is_std || is_pts || is_ptsdts || (mpeg_data == HDR_NO_TS);
   assign rem_last  = (remaining == 16'd1);
   assign ts_final  = (state == TS) && ((ts_idx == 4'd9) || ((ts_idx == 4'd4) && !has_dts));
   assign new_pts   = has_dts ? pts_hold : ts_value;
   assign start_calc = ({1'b0, dclk} + {1'b0, new_pts[32:1]} - {1'b0, scr[32:1]}) & ~33'd1;

   // Lowest-numbered channel wins when several select the same stream_id.
   logic           match_hit;
   logic [CHW-1:0] match_ch;
   always_comb begin
      match_hit = 1'b0;
      match_ch  = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if ((stream_id_sel[8*k +: 8] == mpeg_data) && (mpeg_data != 8'h00)) begin
            match_hit = 1'b1;
            match_ch  = CHW'(k);
         end
      end
   end

   // A header that runs out of packet length is an error unless it just completed.
   logic err_hit;
   always_comb begin
      err_hit = 1'b0;
      if (data_valid) begin
         case (state)
            SC:      err_hit = !sc_known;
            PACK:    err_hit = (pack_idx == 3'd4) && !markers_ok;
            HDR:     err_hit = rem_last ? (mpeg_data != HDR_NO_TS)
                                        : (!hdr_known || (is_stuff && stuff_cnt == 5'(MAX_STUFF)));
            STD2:    err_hit = rem_last;
            TS:      err_hit = rem_last && !ts_final;
            default: err_hit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= HUNT;
         pack_idx      <= '0;
         ts_idx        <= '0;
         has_dts       <= 1'b0;
         matched       <= 1'b0;
         len_hi        <= '0;
         remaining     <= '0;
         stuff_cnt     <= '0;
         ch            <= '0;
         pts_hold      <= '0;
         sel_q         <= '0;
         payload_data  <= '0;
         payload_valid <= 1'b0;
         payload_ch    <= '0;
         payload_last  <= 1'b0;
         scr           <= '0;
         scr_valid     <= 1'b0;
         pts           <= '0;
         dts           <= '0;
         ts_valid      <= 1'b0;
         ts_ch         <= '0;
         start_time    <= '0;
         start_valid   <= '0;
         end_seen      <= 1'b0;
         err_cnt       <= '0;
      end else begin
         payload_valid <= 1'b0;
         payload_last  <= 1'b0;
         scr_valid     <= 1'b0;
         ts_valid      <= 1'b0;
         end_seen      <= 1'b0;
         sel_q         <= stream_id_sel;
         if (err_hit && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;

         if (data_valid) begin
            remaining <= remaining - 16'd1;
            case (state)
               HUNT: state <= (mpeg_data == 8'h00) ? Z1 : HUNT;
               Z1:   state <= (mpeg_data == 8'h00) ? Z2 : HUNT;
               Z2: begin
                  if (mpeg_data == 8'h01)      state <= SC;
                  else if (mpeg_data != 8'h00) state <= HUNT;
               end
               SC: begin
                  state <= HUNT;
                  if (mpeg_data == SC_PACK) begin
                     state    <= PACK;
                     pack_idx <= '0;
                  end else if (mpeg_data == SC_END) begin
                     end_seen <= 1'b1;
                  end else if (mpeg_data == SC_SYSHDR || mpeg_data == SC_PAD || mpeg_data == SC_PRIV2) begin
                     state   <= LEN_H;
                     matched <= 1'b0;
                  end else if (is_es) begin
                     state   <= LEN_H;
                     matched <= match_hit;
                     ch      <= match_ch;
                  end
               end
               PACK: begin
                  pack_idx <= pack_idx + 3'd1;
                  if (pack_idx == 3'd4) begin
                     scr       <= ts_value;
                     scr_valid <= 1'b1;
                  end
                  if (pack_idx == 3'd7)
                     state <= HUNT;
               end
               LEN_H: begin
                  len_hi <= mpeg_data;
                  state  <= LEN_L;
               end
               LEN_L: begin
                  remaining <= {len_hi, mpeg_data};
                  stuff_cnt <= '0;
                  if ({len_hi, mpeg_data} == 16'd0) state <= HUNT;
                  else                              state <= matched ? HDR : SKIP;
               end
               SKIP: if (rem_last) state <= HUNT;
               HDR: begin
                  if (rem_last) begin
                     state <= HUNT;
                  end else if (is_stuff) begin
                     if (stuff_cnt == 5'(MAX_STUFF)) state <= SKIP;
                     else                             stuff_cnt <= stuff_cnt + 5'd1;
                  end else if (is_std) begin
                     state <= STD2;
                  end else if (is_pts || is_ptsdts) begin
                     state   <= TS;
                     ts_idx  <= 4'd1;
                     has_dts <= is_ptsdts;
                  end else if (mpeg_data == HDR_NO_TS) begin
                     state <= PAYLOAD;
                  end else begin
                     state <= SKIP;
                  end
               end
               STD2: state <= rem_last ? HUNT : HDR;
               TS: begin
                  ts_idx <= ts_idx + 4'd1;
                  if (ts_final) begin
                     pts      <= new_pts;
                     dts      <= has_dts ? ts_value : new_pts;
                     ts_valid <= 1'b1;
                     ts_ch    <= ch;
                     for (int k = 0; k < NUM_CH; k++) begin
                        if (CHW'(k) == ch && !start_valid[k]) begin
                           start_time[33*k +: 33] <= start_calc;
                           start_valid[k]         <= 1'b1;
                        end
                     end
                     state <= rem_last ? HUNT : PAYLOAD;
                  end else begin
                     if (ts_idx == 4'd4) pts_hold <= ts_value;
                     if (rem_last)       state <= HUNT;
                  end
               end
               PAYLOAD: begin
                  payload_valid <= 1'b1;
                  payload_data  <= mpeg_data;
                  payload_ch    <= ch;
                  if (rem_last) begin
                     payload_last <= 1'b1;
                     state        <= HUNT;
                  end
               end
               default: state <= HUNT;
            endcase
         end

         // Reprogramming a channel invalidates its start time.
         for (int k = 0; k < NUM_CH; k++) begin
            if (stream_id_sel[8*k +: 8] != sel_q[8*k +: 8])
               start_valid[k] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mpeg_stream_demux.sv
// Randomised packet-level bench for mpeg_stream_demux; expectations come from the packets it builds.
module tb_mpeg_stream_demux;

   localparam int NUM_CH = 3;
   localparam int CHW    = 2;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [7:0]           mpeg_data = 8'h00;
   logic                 data_valid = 1'b0;
   logic [8*NUM_CH-1:0]  stream_id_sel;
   logic [31:0]          dclk = 32'd0;
   logic [7:0]           payload_data;
   logic                 payload_valid;
   logic [CHW-1:0]       payload_ch;
   logic                 payload_last;
   logic [32:0]          scr, pts, dts;
   logic                 scr_valid, ts_valid, end_seen;
   logic [CHW-1:0]       ts_ch;
   logic [33*NUM_CH-1:0] start_time;
   logic [NUM_CH-1:0]    start_valid;
   logic [15:0]          err_cnt;

   mpeg_stream_demux #(.NUM_CH(NUM_CH)) dut (
      .clk(clk), .reset_n(reset_n), .mpeg_data(mpeg_data), .data_valid(data_valid),
      .stream_id_sel(stream_id_sel), .dclk(dclk),
      .payload_data(payload_data), .payload_valid(payload_valid), .payload_ch(payload_ch),
      .payload_last(payload_last), .scr(scr), .scr_valid(scr_valid), .pts(pts), .dts(dts),
      .ts_valid(ts_valid), .ts_ch(ts_ch), .start_time(start_time), .start_valid(start_valid),
      .end_seen(end_seen), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   logic [7:0]  sel [NUM_CH];
   assign stream_id_sel = {sel[2], sel[1], sel[0]};

   int          checks = 0;
   int          errors = 0;
   bit          monitor_on = 1'b0;
   logic [7:0]  pkt[$];
   logic [7:0]  pay_bytes[$];
   logic [63:0] exp_pay[$];
   logic [32:0] exp_scr[$];
   logic [32:0] exp_pts[$];
   logic [32:0] exp_dts[$];
   int          exp_tsch[$];
   int          exp_err = 0;
   int          exp_end = 0;
   int          seen_end = 0;
   logic [32:0] scr_cur = '0;
   bit          exp_sv [NUM_CH];
   logic [32:0] exp_st [NUM_CH];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [39:0] encodeTs(input logic [3:0] prefix, input logic [32:0] v);
      return {prefix, v[32:30], 1'b1, v[29:22], v[21:15], 1'b1, v[14:7], v[6:0], 1'b1};
   endfunction

   function automatic logic [32:0] rand33();
      return {1'($urandom_range(1)), 32'($urandom)};
   endfunction

   function automatic int findChannel(input logic [7:0] sid);
      for (int k = 0; k < NUM_CH; k++)
         if (sel[k] == sid && sel[k] != 8'h00) return k;
      return -1;
   endfunction

   // One stream byte, sometimes followed by an idle cycle carrying garbage.
   task automatic applyStimulus(input logic [7:0] b);
      mpeg_data  = b;
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      if ($urandom_range(3) == 0) begin
         mpeg_data = 8'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic sendPkt();
      foreach (pkt[i]) applyStimulus(pkt[i]);
      pkt.delete();
   endtask

   task automatic pushStart(input logic [7:0] code);
      if ($urandom_range(3) == 0) pkt.push_back(8'($urandom_range(255, 2)));
      if ($urandom_range(3) == 0) pkt.push_back(8'h00);
      pkt.push_back(8'h00); pkt.push_back(8'h00); pkt.push_back(8'h01); pkt.push_back(code);
   endtask

   task automatic randPay(input int n);
      pay_bytes.delete();
      for (int i = 0; i < n; i++) pay_bytes.push_back(8'($urandom));
   endtask

   task automatic genPack(input logic [32:0] s, input bit bad_marker);
      logic [39:0] e;
      e = encodeTs(4'h2, s);
      if (bad_marker) e[16] = 1'b0;
      pushStart(8'hBA);
      for (int i = 4; i >= 0; i--) pkt.push_back(e[8*i +: 8]);
      pkt.push_back(8'h80); pkt.push_back(8'h00); pkt.push_back(8'h01);
      scr_cur = s;
      exp_scr.push_back(s);
      if (bad_marker) exp_err++;
      sendPkt();
   endtask

   task automatic genPes(input logic [7:0] sid, input int stuff_n, input bit with_std,
                         input int ts_mode, input logic [32:0] p, input logic [32:0] d);
      logic [7:0]  hdr[$];
      logic [39:0] e;
      int          k, len;
      for (int i = 0; i < stuff_n; i++) hdr.push_back(8'hFF);
      if (with_std) begin
         hdr.push_back(8'h40 | 8'($urandom_range(63)));
         hdr.push_back(8'($urandom));
      end
      if (ts_mode == 0) hdr.push_back(8'h0F);
      else begin
         e = encodeTs((ts_mode == 1) ? 4'h2 : 4'h3, p);
         for (int i = 4; i >= 0; i--) hdr.push_back(e[8*i +: 8]);
         if (ts_mode == 2) begin
            e = encodeTs(4'h1, d);
            for (int i = 4; i >= 0; i--) hdr.push_back(e[8*i +: 8]);
         end
      end
      len = hdr.size() + pay_bytes.size();
      pushStart(sid);
      pkt.push_back(8'(len >> 8)); pkt.push_back(8'(len));
      foreach (hdr[i]) pkt.push_back(hdr[i]);
      foreach (pay_bytes[i]) pkt.push_back(pay_bytes[i]);
      k = findChannel(sid);
      if (k >= 0) begin
         if (ts_mode != 0) begin
            exp_pts.push_back(p);
            exp_dts.push_back((ts_mode == 2) ? d : p);
            exp_tsch.push_back(k);
            if (!exp_sv[k]) begin
               exp_sv[k] = 1'b1;
               exp_st[k] = (33'(dclk) + (p >> 1) - (scr_cur >> 1)) & ~33'd1;
            end
         end
         foreach (pay_bytes[i])
            exp_pay.push_back(64'({(i == pay_bytes.size() - 1), 2'(k), pay_bytes[i]}));
      end
      sendPkt();
   endtask

   task automatic genSkipped(input logic [7:0] code);
      int n;
      n = $urandom_range(6);
      pushStart(code);
      pkt.push_back(8'h00); pkt.push_back(8'(n));
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      sendPkt();
   endtask

   task automatic randomTraffic(input int n);
      logic [7:0] sids [5];
      sids = '{8'hE0, 8'hC0, 8'hC1, 8'hE1, 8'hE5};
      for (int it = 0; it < n; it++) begin
         int kind;
         kind = $urandom_range(9);
         if (kind <= 1) genPack(rand33(), $urandom_range(7) == 0);
         else if (kind <= 6) begin
            dclk = $urandom;
            randPay($urandom_range(10));
            genPes(sids[$urandom_range(4)], $urandom_range(3), 1'($urandom_range(1)),
                   $urandom_range(2), rand33(), rand33());
         end
         else if (kind == 7) genSkipped(8'hBE);
         else if (kind == 8) genSkipped(8'hBB);
         else begin
            pushStart(8'hB9); exp_end++; sendPkt();
         end
      end
   endtask

   task automatic checkStatus(input string tag);
      logic [NUM_CH-1:0] sv_vec;
      repeat (2) @(negedge clk);
      #1;
      checkOutput({tag, "_pay_left"}, exp_pay.size(), 0);
      checkOutput({tag, "_ts_left"}, exp_pts.size(), 0);
      checkOutput({tag, "_scr_left"}, exp_scr.size(), 0);
      checkOutput({tag, "_err_cnt"}, err_cnt, exp_err);
      checkOutput({tag, "_end_seen"}, seen_end, exp_end);
      for (int k = 0; k < NUM_CH; k++) sv_vec[k] = exp_sv[k];
      checkOutput({tag, "_start_valid"}, start_valid, sv_vec);
      for (int k = 0; k < NUM_CH; k++)
         if (exp_sv[k]) checkOutput($sformatf("%s_start_time%0d", tag, k), start_time[33*k +: 33], exp_st[k]);
   endtask

   // Every output strobe is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (monitor_on) begin
         if (payload_valid) begin
            if (exp_pay.size() == 0) checkOutput("payload_extra", payload_valid, 0);
            else checkOutput("payload", 64'({payload_last, payload_ch, payload_data}), exp_pay.pop_front());
         end
         if (scr_valid) begin
            if (exp_scr.size() == 0) checkOutput("scr_extra", scr_valid, 0);
            else checkOutput("scr", scr, exp_scr.pop_front());
         end
         if (ts_valid) begin
            if (exp_pts.size() == 0) checkOutput("ts_extra", ts_valid, 0);
            else begin
               checkOutput("pts", pts, exp_pts.pop_front());
               checkOutput("dts", dts, exp_dts.pop_front());
               checkOutput("ts_ch", ts_ch, exp_tsch.pop_front());
            end
         end
         if (end_seen) seen_end++;
      end
   end

   initial begin
      sel = '{8'hE0, 8'hC0, 8'h00};
      for (int k = 0; k < NUM_CH; k++) begin exp_sv[k] = 1'b0; exp_st[k] = '0; end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_payload_valid", payload_valid, 0);
      checkOutput("reset_scr", scr, 0);
      checkOutput("reset_pts", pts, 0);
      checkOutput("reset_err_cnt", err_cnt, 0);
      checkOutput("reset_start_valid", start_valid, 0);
      checkOutput("reset_start_time0", start_time[32:0], 0);
      reset_n = 1'b1;
      monitor_on = 1'b1;
      @(posedge clk); #1;

      genPack(33'd0, 1'b0);
      checkStatus("pack0");

      genPack(33'd90000, 1'b0);
      randPay(7);
      genPes(8'hE0, 0, 1'b0, 0, '0, '0);
      checkStatus("plain_pes");

      genPack(33'd4000, 1'b0);
      dclk = 32'd1000;
      randPay(2);
      genPes(8'hE0, 0, 1'b0, 1, 33'd11760, '0);
      checkStatus("first_pts");
      checkOutput("plan_start_time", start_time[32:0], 33'd4880);
      dclk = 32'd77777;
      randPay(3);
      genPes(8'hE0, 2, 1'b1, 2, 33'd20000, 33'd15000);
      checkStatus("second_pts");

      pay_bytes = '{8'h00, 8'h00, 8'h01, 8'hBA};
      dclk = 32'd5;
      genPes(8'hC0, 1, 1'b0, 1, 33'd9000, '0);
      pay_bytes = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h00};
      genPes(8'hE1, 0, 1'b0, 0, '0, '0);
      randPay(4);
      genPes(8'hC0, 0, 1'b0, 0, '0, '0);
      checkStatus("filter");

      pkt = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h03, 8'h31, 8'h11, 8'h01};
      exp_err++;
      sendPkt();
      checkStatus("truncated");

      pkt = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'd20};
      for (int i = 0; i < 17; i++) pkt.push_back(8'hFF);
      pkt.push_back(8'h0F); pkt.push_back(8'hAA); pkt.push_back(8'hBB);
      exp_err++;
      sendPkt();
      pushStart(8'hB5); exp_err++; sendPkt();
      pushStart(8'hB9); exp_end++; sendPkt();
      checkStatus("errors");

      randomTraffic(40);
      checkStatus("random1");

      sel[1] = 8'hC1;
      exp_sv[1] = 1'b0;
      @(posedge clk); #1;
      sel[2] = 8'hC0;
      exp_sv[2] = 1'b0;
      checkStatus("sel_change");
      randomTraffic(30);
      checkStatus("random2");

      monitor_on = 1'b0;
      pkt = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'd11, 8'h0F};
      for (int i = 0; i < 10; i++) pkt.push_back(8'($urandom));
      for (int i = 0; i < 10; i++) applyStimulus(pkt[i]);
      mpeg_data  = pkt[10];
      data_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("pre_reset_payload_valid", payload_valid, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_payload_valid", payload_valid, 0);
      checkOutput("midreset_err_cnt", err_cnt, 0);
      checkOutput("midreset_scr", scr, 0);
      checkOutput("midreset_start_valid", start_valid, 0);
      data_valid = 1'b0;
      pkt.delete();
      exp_err = 0; exp_end = 0; seen_end = 0; scr_cur = '0;
      for (int k = 0; k < NUM_CH; k++) exp_sv[k] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      monitor_on = 1'b1;
      @(posedge clk); #1;
      genPack(rand33(), 1'b0);
      randPay(5);
      genPes(8'hE0, 0, 1'b0, 1, rand33(), '0);
      randomTraffic(15);
      checkStatus("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
